spi_master_param: RTL
=====================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 The block SHALL use parameter CLK_DIV, default 10, meaning clk cycles per sclk period (even, >=4); the half period H = CLK_DIV/2.
REQ-002 The block SHALL use parameter ADDR_W, default 7, meaning address field width.
REQ-003 The block SHALL use parameter DATA_W, default 8, meaning data field width; FRAME_W = 1+ADDR_W+DATA_W (default 16).
REQ-004 The block SHALL use parameter NUM_CS, default 1, meaning chip-select count; CS_W = max(1, clog2(NUM_CS)).
REQ-005 The block SHALL have port clk  in  1  single system clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port tx_data  in  FRAME_W  frame: MSB = R/W (1 = read), then address, then data.
REQ-008 The block SHALL have port tx_valid  in  1  frame request.
REQ-009 The block SHALL have port tx_ready  out  1  block idle, request accepted this cycle.
REQ-010 The block SHALL have port cs_sel  in  CS_W  target chip select, sampled on accept.
REQ-011 The block SHALL have ports cpol, cpha  in  1 each  SPI mode, sampled on accept.
REQ-012 The block SHALL have port rdata  out  DATA_W  last read data.
REQ-013 The block SHALL have port rdata_valid  out  1  one-cycle pulse when rdata is updated.
REQ-014 The block SHALL have port busy  out  1  frame in progress.
REQ-015 The block SHALL have ports sclk, mosi  out  1 each, csn  out  NUM_CS  (active low), and miso  in  1.

Function
REQ-016 A frame SHALL be accepted when tx_valid && tx_ready; tx_data, cs_sel, cpol and cpha are latched on that cycle, and changes to them during the frame SHALL be ignored.
REQ-017 tx_ready SHALL be high only in IDLE; requests seen while busy SHALL be ignored.
REQ-018 The FSM SHALL have states IDLE -> SETUP (H cycles) -> XFER (FRAME_W x CLK_DIV cycles) -> HOLD (H cycles) -> IDLE.
REQ-019 csn[cs_sel] SHALL go low the cycle after accept and return high after exactly (FRAME_W+1) x CLK_DIV cycles; cs_sel >= NUM_CS SHALL run the frame with no csn asserted.
REQ-020 Within each XFER bit, sclk SHALL equal cpol for the first H cycles and ~cpol for the last H; sclk SHALL equal the latched cpol in SETUP and HOLD.
REQ-021 With cpha=0, mosi SHALL change at bit start and miso SHALL be sampled at mid-bit; with cpha=1, mosi SHALL change at mid-bit and miso SHALL be sampled at bit end.
REQ-022 Bits SHALL be sent MSB first; mosi SHALL be 1 outside frames.
REQ-023 For read frames, rdata SHALL hold the last DATA_W sampled bits (MSB first), and rdata_valid SHALL pulse for 1 cycle coincident with csn rising.
REQ-024 Write frames SHALL leave rdata unchanged and produce no pulse.
REQ-025 tx_ready SHALL reassert the cycle after csn rises, so the minimum csn-high gap is 2 cycles.

Reset
REQ-026 On rst_n low, the block SHALL immediately force IDLE, sclk=0, csn all 1, mosi=1, tx_ready=1, busy=0, rdata=0 and rdata_valid=0, including mid-frame; the latched cpol SHALL reset to 0.

Configuration
REQ-027 With SPI_LOOPBACK_EN defined, the sampler SHALL take the internal mosi value and ignore miso; without it, the sampler SHALL take miso.

Structure
REQ-028 Package spi_pkg SHALL hold the FSM state enum, the mode constants (MODE0..MODE3) and the FRAME_W computation.
REQ-029 Sub-module spi_clkgen SHALL contain the divider counter and generate the start/mid/end-of-bit strobes.

Verification (defaults)
REQ-030 Mode 0 write 16'h2A5C -> the 16 sclk rising edges see mosi 0010101001011100, csn[0] is low for 170 cycles, and there is no rdata_valid.
REQ-031 Mode 3 read 16'h8100 with the slave driving 8'hC3 -> rdata=8'hC3, with a 1-cycle rdata_valid at csn rise, and sclk idles high.
REQ-032 tx_valid held high for two frames -> the second frame is accepted the cycle after csn rises, giving a csn-high gap of exactly 2 cycles.
REQ-033 rst_n asserted at bit 5 -> outputs take reset values the same cycle, and a new frame runs correctly after release.
REQ-034 SPI_LOOPBACK_EN, read 16'h80A5 -> rdata=8'hA5 regardless of miso.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parameterised SPI master: FSM states,
// SPI mode encodings {cpol, cpha} and frame/chip-select width calculations.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // R/W bit + address + data
    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int unsigned cs_w(input int unsigned num_cs);
        return (num_cs <= 1) ? 1 : unsigned'($clog2(num_cs));
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Divider counter for the SPI master; flags the cycle before a bit start,
// the last cycle of the first half-bit and the last cycle of a bit.
module spi_clkgen #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic start_c,
    output logic mid_c,
    output logic end_c
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign mid_c   = en && (cnt == CNT_W'(HALF - 1));
    assign end_c   = en && (cnt == CNT_W'(CLK_DIV - 1));
    // next cycle is the first cycle of a bit
    assign start_c = en && (restart || end_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || restart || end_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one R/W + address + data frame per request, MSB first.
// Define SPI_LOOPBACK_EN to sample the internal mosi instead of miso.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 10,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_CS  = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [frame_w(ADDR_W, DATA_W)-1:0] tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    input  logic [cs_w(NUM_CS)-1:0]           cs_sel,
    input  logic                              cpol,
    input  logic                              cpha,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              rdata_valid,
    output logic                              busy,
    output logic                              sclk,
    output logic                              mosi,
    output logic [NUM_CS-1:0]                 csn,
    input  logic                              miso
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CS_W    = cs_w(NUM_CS);
    localparam int unsigned BIT_W   = $clog2(FRAME_W);

    spi_state_e         state;
    spi_state_e         state_nxt;
    logic [FRAME_W-1:0] tx_sr;
    logic [DATA_W-1:0]  rx_sr;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CS_W-1:0]    cs_l;
    logic [1:0]         mode_l;
    logic               rd_l;

    logic               accept_c;
    logic               restart_c;
    logic               start_c;
    logic               mid_c;
    logic               end_c;
    logic               last_bit_c;
    logic               cpol_l_c;
    logic               cpha_l_c;
    logic               drive_c;
    logic               sample_c;
    logic               rx_bit_c;
    logic [CS_W-1:0]    cs_nxt_c;

    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state != ST_IDLE),
        .restart (restart_c),
        .start_c (start_c),
        .mid_c   (mid_c),
        .end_c   (end_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SETUP and HOLD each last half a bit; XFER runs FRAME_W full bits
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        restart_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    accept_c  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (mid_c) begin
                    restart_c = 1'b1;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (end_c && last_bit_c) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (mid_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cpol_l_c   = (mode_l == MODE2) || (mode_l == MODE3);
    assign cpha_l_c   = (mode_l == MODE1) || (mode_l == MODE3);
    assign last_bit_c = (bit_cnt == BIT_W'(FRAME_W - 1));
    assign cs_nxt_c   = accept_c ? cs_sel : cs_l;

    // cpha=0 presents each bit from its start, cpha=1 from mid-bit
    assign drive_c  = cpha_l_c ? ((state == ST_XFER) && mid_c)
                               : (start_c && ((state == ST_SETUP) ||
                                              ((state == ST_XFER) && !last_bit_c)));
    assign sample_c = (state == ST_XFER) && (cpha_l_c ? end_c : mid_c);

`ifdef SPI_LOOPBACK_EN
    assign rx_bit_c = mosi;
`else
    assign rx_bit_c = miso;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            cs_l    <= '0;
            mode_l  <= MODE0;
            rd_l    <= 1'b0;
        end else if (accept_c) begin
            tx_sr   <= tx_data;
            cs_l    <= cs_sel;
            mode_l  <= {cpol, cpha};
            rd_l    <= tx_data[FRAME_W-1];
            bit_cnt <= '0;
        end else begin
            if (drive_c) begin
                tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            end
            if (sample_c) begin
                rx_sr <= {rx_sr[DATA_W-2:0], rx_bit_c};
            end
            if ((state == ST_XFER) && end_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // Pin-level outputs, aligned with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk        <= 1'b0;
            mosi        <= 1'b1;
            csn         <= '1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            tx_ready    <= (state == ST_IDLE) && (state_nxt == ST_IDLE);
            busy        <= (state_nxt != ST_IDLE);
            rdata_valid <= 1'b0;

            for (int i = 0; i < NUM_CS; i++) begin
                csn[i] <= !((state_nxt != ST_IDLE) && (cs_nxt_c == CS_W'(i)));
            end

            if (accept_c) begin
                sclk <= cpol;
            end else if ((state == ST_XFER) && mid_c) begin
                sclk <= !cpol_l_c;
            end else if ((state == ST_XFER) && end_c) begin
                sclk <= cpol_l_c;
            end

            if (drive_c) begin
                mosi <= tx_sr[FRAME_W-1];
            end else if (state_nxt == ST_IDLE) begin
                mosi <= 1'b1;
            end

            if ((state == ST_HOLD) && (state_nxt == ST_IDLE) && rd_l) begin
                rdata       <= rx_sr;
                rdata_valid <= 1'b1;
            end
        end
    end

endmodule
